// File: rtl/tt_pin_pkg.sv
// Shared types and constants for the Tiny Tapeout pin-interface host.
// State encoding, pin bit positions and datapath widths.
package tt_pin_pkg;

  localparam int unsigned TT_W    = 8;
  localparam int unsigned TO_W    = 16;
  localparam int unsigned REQ_BIT = 0;
  localparam int unsigned ACK_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    DROP
  } state_e;

endpackage

// File: rtl/tt_sync_chain.sv
// Single-bit synchroniser: STAGES flops in series, cleared by async reset.
module tt_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/tt_pin_host.sv
// Host-side initiator for the Tiny Tapeout pin interface: turns a valid/ready
// command byte into a four-phase req/ack handshake and returns uo_out.
module tt_pin_host
  import tt_pin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SETUP_CYCLES   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [TT_W-1:0] cmd_data,
  output logic            rsp_valid,
  output logic [TT_W-1:0] rsp_data,
  output logic            rsp_timeout,
  output logic [TT_W-1:0] pin_ui_in,
  output logic [TT_W-1:0] pin_uio_in,
  input  logic [TT_W-1:0] pin_uo_out,
  input  logic [TT_W-1:0] pin_uio_out,
  input  logic [TT_W-1:0] pin_uio_oe
);

  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      SETUP_LOAD = 4'(SETUP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TT_W-1:0] ui_q, ui_d;
  logic [3:0]      setup_cnt_q, setup_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            armed_q, armed_d;
  logic            abort_q, abort_d;
  logic [TT_W-1:0] cap_q, cap_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [TT_W-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            init_q, init_d;

  logic            ack_raw;
  logic            ack_s;
  logic            ack_ok;
  logic            req;
  logic            to_hit;
  logic [TO_W-1:0] to_inc;
  logic            unused_pins;

  assign ack_raw = pin_uio_out[ACK_BIT] & pin_uio_oe[ACK_BIT];

  tt_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ack_raw),
    .q    (ack_s)
  );

  // An ack only counts once ack_s has been seen low during this REQ, so a
  // stale high ack left over from before req rose can never complete a transfer.
  assign ack_ok = armed_q & ack_s;

  // req falls in the same cycle a valid ack_s arrives; the state register
  // follows on the next edge, when uo_out is captured.
  assign req    = (state_q == REQ) & ~ack_ok;

  assign to_hit = (to_cnt_q >= TO_LAST);
  assign to_inc = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;

  assign cmd_ready   = (state_q == IDLE) & init_q & ~rsp_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign pin_ui_in   = ui_q;

  always_comb begin
    pin_uio_in          = '0;
    pin_uio_in[REQ_BIT] = req;
  end

  always_comb begin
    state_d       = state_q;
    ui_d          = ui_q;
    setup_cnt_d   = setup_cnt_q;
    to_cnt_d      = to_cnt_q;
    armed_d       = armed_q;
    abort_d       = abort_q;
    cap_d         = cap_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    init_d        = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ui_d        = cmd_data;
          setup_cnt_d = SETUP_LOAD;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        if (setup_cnt_q == '0) begin
          to_cnt_d = '0;
          armed_d  = 1'b0;
          abort_d  = 1'b0;
          state_d  = REQ;
        end else begin
          setup_cnt_d = setup_cnt_q - 1'b1;
        end
      end

      REQ: begin
        if (!ack_s) begin
          armed_d = 1'b1;
        end
        if (ack_ok) begin
          cap_d    = pin_uo_out;
          to_cnt_d = '0;
          state_d  = DROP;
        end else if (to_hit) begin
          cap_d    = '0;
          abort_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = DROP;
        end else begin
          to_cnt_d = to_inc;
        end
      end

      DROP: begin
        if (!ack_s) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = cap_q;
          rsp_timeout_d = abort_q;
          state_d       = IDLE;
        end else if (to_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = cap_q;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ui_q          <= '0;
      setup_cnt_q   <= '0;
      to_cnt_q      <= '0;
      armed_q       <= 1'b0;
      abort_q       <= 1'b0;
      cap_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ui_q          <= ui_d;
      setup_cnt_q   <= setup_cnt_d;
      to_cnt_q      <= to_cnt_d;
      armed_q       <= armed_d;
      abort_q       <= abort_d;
      cap_q         <= cap_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      init_q        <= init_d;
    end
  end

  assign unused_pins = ^{pin_uio_out[TT_W-1:ACK_BIT+1], pin_uio_out[ACK_BIT-1:0],
                         pin_uio_oe[TT_W-1:ACK_BIT+1], pin_uio_oe[ACK_BIT-1:0]};

endmodule

// File: tb/tb_tt_pin_host.sv
// Self-checking bench for tt_pin_host with a simple pin-side design model.
module tb_tt_pin_host;

  localparam int unsigned TO   = 10;
  localparam int unsigned SYNC = 2;

  typedef enum int {M_ECHO, M_SILENT, M_NOOE, M_STUCK} mode_e;

  typedef struct {
    logic [7:0]  cmd;
    mode_e       m;
    logic [7:0]  uo;
    int unsigned d;
    logic [7:0]  exp_data;
    logic        exp_to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [7:0] pin_ui_in;
  logic [7:0] pin_uio_in;
  logic [7:0] pin_uo_out;
  logic [7:0] pin_uio_out;
  logic [7:0] pin_uio_oe;

  always #5 clk = ~clk;

  tt_pin_host #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TO),
    .SETUP_CYCLES  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .pin_ui_in  (pin_ui_in),
    .pin_uio_in (pin_uio_in),
    .pin_uo_out (pin_uo_out),
    .pin_uio_out(pin_uio_out),
    .pin_uio_oe (pin_uio_oe)
  );

  // Pin-side design model: acks dly cycles after it registers req.
  mode_e       mode = M_SILENT;
  int unsigned dly = 1;
  logic [7:0]  uo_val = '0;
  logic        uo_follow = 1'b0;
  logic [7:0]  hist = '0;

  always @(posedge clk) hist <= {hist[6:0], pin_uio_in[0]};

  always_comb begin
    pin_uio_out = '0;
    pin_uio_oe  = '0;
    case (mode)
      M_ECHO: begin
        pin_uio_oe[1]  = 1'b1;
        pin_uio_out[1] = hist[dly-1];
      end
      M_NOOE:  pin_uio_out[1] = 1'b1;
      M_STUCK: begin
        pin_uio_out[1] = 1'b1;
        pin_uio_oe[1]  = 1'b1;
      end
      default: ;
    endcase
    pin_uo_out = uo_follow ? pin_ui_in + 8'h10 : uo_val;
  end

  // Monitor
  int unsigned rsp_count = 0;
  logic [8:0]  rsp_log[$];
  logic        prev_req = 1'b0;
  int unsigned req_run = 0;
  int unsigned last_req_len = 0;
  logic [7:0]  last_req_ui = '0;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_count = rsp_count + 1;
      rsp_log.push_back({rsp_data, rsp_timeout});
    end
    if (pin_uio_in[0]) begin
      if (!prev_req) last_req_ui = pin_ui_in;
      req_run = req_run + 1;
    end else if (prev_req) begin
      last_req_len = req_run;
      req_run = 0;
    end
    prev_req = pin_uio_in[0];
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: a transfer completes only if the ack round trip through the
  // synchroniser lands before the timeout; otherwise it aborts with data 0.
  function automatic logic [8:0] ref_rsp(input mode_e m, input logic [7:0] uo, input int unsigned d);
    if (m == M_ECHO && d + SYNC < TO) return {uo, 1'b0};
    return {8'h00, 1'b1};
  endfunction

  task automatic run_txn(input string tag, input logic [7:0] cmd, input mode_e m,
                         input logic [7:0] uo, input int unsigned d,
                         input logic [7:0] exp_data, input logic exp_to);
    int unsigned base;
    int unsigned i;
    logic [8:0]  r;
    tick();
    mode   = m;
    dly    = d;
    uo_val = uo;
    if (m == M_STUCK) repeat (4) tick();
    base      = rsp_count;
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    i = 0;
    while (!cmd_ready && i < 50) begin
      tick();
      i++;
    end
    if (!cmd_ready) begin
      check({tag, " accept"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    i = 0;
    while (rsp_count == base && i < 200) begin
      tick();
      i++;
    end
    check({tag, " rsp seen"}, rsp_count - base, 1);
    if (rsp_count != base) begin
      r = rsp_log[rsp_log.size()-1];
      check({tag, " rsp_data"}, r[8:1], exp_data);
      check({tag, " rsp_timeout"}, r[0], exp_to);
    end
    check({tag, " ui at req"}, last_req_ui, cmd);
    check({tag, " req len"}, last_req_len, (m == M_ECHO) ? d + SYNC : TO);
    mode = M_SILENT;
    repeat (4) tick();
    check({tag, " single rsp"}, rsp_count - base, 1);
    check({tag, " ready after"}, cmd_ready, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tbl[6];
    int          exp_req[10];
    int          exp_rv[10];
    int          exp_rdy[10];
    int unsigned base;
    int unsigned i;
    int unsigned n;
    logic        prev_rdy;
    logic [8:0]  e;
    logic [7:0]  rc, ru;
    int unsigned rd, rm;
    mode_e       mm;

    tbl[0] = '{8'hA5, M_ECHO,   8'h3C, 1, 8'h3C, 1'b0};
    tbl[1] = '{8'h5A, M_SILENT, 8'h99, 1, 8'h00, 1'b1};
    tbl[2] = '{8'hC3, M_NOOE,   8'h77, 1, 8'h00, 1'b1};
    tbl[3] = '{8'hC3, M_ECHO,   8'h77, 1, 8'h77, 1'b0};
    tbl[4] = '{8'hE7, M_STUCK,  8'h11, 1, 8'h00, 1'b1};
    tbl[5] = '{8'h42, M_ECHO,   8'h8E, 3, 8'h8E, 1'b0};

    exp_req = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    exp_rv  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    exp_rdy = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    // Reset with a command already offered
    cmd_valid = 1'b1;
    cmd_data  = 8'h77;
    repeat (3) @(negedge clk);
    #1;
    check("reset cmd_ready", cmd_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset pin_uio_in", pin_uio_in, 0);
    rst_n = 1'b1;
    check("release ready low", cmd_ready, 0);
    tick();
    check("ready after release", cmd_ready, 1);
    check("no accept in reset", pin_ui_in, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_timeout", rsp_timeout, 0);
    cmd_valid = 1'b0;

    // Minimum-latency transfer, edge by edge from the accept edge
    tick();
    mode      = M_ECHO;
    dly       = 1;
    uo_val    = 8'h3C;
    cmd_data  = 8'hA5;
    cmd_valid = 1'b1;
    check("lat ready", cmd_ready, 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        cmd_valid = 1'b0;
        check("lat ui before req", pin_ui_in, 8'hA5);
      end
      check($sformatf("lat req e%0d", k), pin_uio_in, exp_req[k]);
      check($sformatf("lat rsp_valid e%0d", k), rsp_valid, exp_rv[k]);
      check($sformatf("lat cmd_ready e%0d", k), cmd_ready, exp_rdy[k]);
      if (k == 8) begin
        check("lat rsp_data", rsp_data, 8'h3C);
        check("lat rsp_timeout", rsp_timeout, 0);
      end
    end
    mode = M_SILENT;
    repeat (3) tick();

    for (int v = 0; v < 6; v++) begin
      run_txn($sformatf("tbl%0d", v), tbl[v].cmd, tbl[v].m, tbl[v].uo, tbl[v].d,
              tbl[v].exp_data, tbl[v].exp_to);
    end

    for (int v = 0; v < 20; v++) begin
      rm = $urandom_range(0, 3);
      mm = (rm == 0) ? M_SILENT : (rm == 1) ? M_NOOE : M_ECHO;
      rc = 8'($urandom);
      ru = 8'($urandom);
      rd = $urandom_range(1, 4);
      e  = ref_rsp(mm, ru, rd);
      run_txn($sformatf("rand%0d", v), rc, mm, ru, rd, e[8:1], e[0]);
    end

    // Back-to-back with cmd_valid held; the design echoes ui_in + 0x10
    tick();
    mode      = M_ECHO;
    dly       = 1;
    uo_follow = 1'b1;
    base      = rsp_count;
    n         = 0;
    cmd_data  = 8'h01;
    cmd_valid = 1'b1;
    prev_rdy  = cmd_ready;
    i = 0;
    while (i < 300 && !(n == 3 && rsp_count == base + 3)) begin
      tick();
      i++;
      if (prev_rdy && n < 3) begin
        n++;
        if (n == 3) cmd_valid = 1'b0;
        else cmd_data = 8'(n + 1);
      end
      prev_rdy = cmd_ready;
    end
    check("b2b count", rsp_count - base, 3);
    if (rsp_count - base == 3) begin
      for (int j = 0; j < 3; j++) begin
        e = rsp_log[rsp_log.size() - 3 + j];
        check($sformatf("b2b data%0d", j), e[8:1], 8'(j + 8'h11));
        check($sformatf("b2b timeout%0d", j), e[0], 0);
      end
    end
    uo_follow = 1'b0;
    mode      = M_SILENT;
    repeat (4) tick();

    // Asynchronous reset while req is high
    cmd_data  = 8'h5E;
    cmd_valid = 1'b1;
    i = 0;
    while (!pin_uio_in[0] && i < 20) begin
      tick();
      if (!cmd_ready) cmd_valid = 1'b0;
      i++;
    end
    cmd_valid = 1'b0;
    check("midreq req seen", pin_uio_in[0], 1);
    base = rsp_count;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreq req drop", pin_uio_in[0], 0);
    check("midreq ready", cmd_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("midreq no rsp", rsp_count - base, 0);
    check("midreq idle ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
